// File: rtl/boot_sram_loader_if.sv
// Bundles the Avalon-ST byte sink, the Avalon-MM s1 write port and the frame status of boot_sram_loader.
`default_nettype none

interface boot_sram_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] sram_address;
    logic              sram_chipselect;
    logic              sram_write;
    logic [7:0]        sram_writedata;
    logic              sram_clken;
    logic              busy;
    logic              done;
    logic              error;

    // master: the loader (drives the SRAM and status, sinks the stream)
    modport master (
        input  in_data, in_valid,
        output in_ready, sram_address, sram_chipselect, sram_write,
        output sram_writedata, sram_clken, busy, done, error
    );

    // slave: the environment (stream source, SRAM, controlling CPU)
    modport slave (
        output in_data, in_valid,
        input  in_ready, sram_address, sram_chipselect, sram_write,
        input  sram_writedata, sram_clken, busy, done, error
    );
endinterface

`default_nettype wire

// File: rtl/boot_sram_loader.sv
// boot_sram_loader: framed byte-stream loader writing payload into the 64 KiB boot SRAM.
// Optional trailing checksum byte and error pulse: BOOT_SRAM_LOADER_CHECKSUM_EN. Rev 1.0
`default_nettype none

module boot_sram_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ADDR_W    = 16
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    boot_sram_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        LEN_HI  = 3'd3,
        LEN_LO  = 3'd4,
        DATA    = 3'd5,
        CSUM    = 3'd6,
        REPORT  = 3'd7
    } state_t;

`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    localparam state_t POST_DATA = CSUM;
`else
    localparam state_t POST_DATA = REPORT;
`endif

    state_t            state;
    state_t            state_nx;
    logic              enabled;
    logic              accept;
    logic [15:0]       addr;
    logic [15:0]       count;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              done_q;
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
    logic              error_q;
`endif

    // enabled rises on the first clock out of reset and gates both in_ready and clken
    assign bus.in_ready        = enabled && (state != REPORT);
    assign accept              = bus.in_valid && bus.in_ready;
    assign bus.sram_clken      = enabled;
    assign bus.sram_address    = wr_addr;
    assign bus.sram_writedata  = wr_data;
    assign bus.sram_chipselect = wr_en;
    assign bus.sram_write      = wr_en;
    assign bus.busy            = (state != IDLE);
    assign bus.done            = done_q;
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    assign bus.error           = error_q;
`else
    assign bus.error           = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && bus.in_data == SYNC_BYTE) state_nx = ADDR_HI;
            ADDR_HI: if (accept) state_nx = ADDR_LO;
            ADDR_LO: if (accept) state_nx = LEN_HI;
            LEN_HI:  if (accept) state_nx = LEN_LO;
            LEN_LO:  if (accept) state_nx = ({count[15:8], bus.in_data} != 16'd0) ? DATA : POST_DATA;
            DATA:    if (accept && count == 16'd1) state_nx = POST_DATA;
            CSUM:    if (accept) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // done/error are registered off REPORT so they land after the final SRAM write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enabled <= 1'b0;
            addr    <= 16'd0;
            count   <= 16'd0;
            wr_addr <= '0;
            wr_data <= 8'd0;
            wr_en   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            enabled <= 1'b1;
            wr_en   <= 1'b0;
            done_q  <= (state == REPORT);
            if (accept) begin
                case (state)
                    ADDR_HI: addr[15:8]  <= bus.in_data;
                    ADDR_LO: addr[7:0]   <= bus.in_data;
                    LEN_HI:  count[15:8] <= bus.in_data;
                    LEN_LO:  count[7:0]  <= bus.in_data;
                    DATA: begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr[ADDR_W-1:0];
                        wr_data <= bus.in_data;
                        addr    <= addr + 16'd1;
                        count   <= count - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum     <= 8'd0;
            error_q <= 1'b0;
        end else begin
            error_q <= (state == REPORT) && (sum != 8'd0);
            if (accept) begin
                if (state == IDLE)
                    sum <= 8'd0;
                else if (state != REPORT)
                    sum <= sum + bus.in_data;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_boot_sram_loader.sv
// Directed self-checking bench for boot_sram_loader; works with or without BOOT_SRAM_LOADER_CHECKSUM_EN.
`default_nettype none

module tb_boot_sram_loader;

`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    boot_sram_loader_if #(.ADDR_W(16)) bus ();

    boot_sram_loader #(.SYNC_BYTE(8'hA5), .ADDR_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    int          done_cnt = 0;
    int          ovl = 0;
    int          cs_bad = 0;
    int          stray_err = 0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (bus.sram_write) begin
            wa.push_back(bus.sram_address);
            wd.push_back(bus.sram_writedata);
            wc.push_back(cyc);
            if (!bus.sram_chipselect) cs_bad++;
        end
        if (bus.done) begin
            done_cnt++;
            last_err = bus.error;
            if (bus.sram_write) ovl++;
        end
        if (bus.error && !bus.done) stray_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        wa.delete();
        wd.delete();
        wc.delete();
        done_cnt  = 0;
        ovl       = 0;
        cs_bad    = 0;
        stray_err = 0;
        last_err  = 1'b0;
    endtask

    // presents one byte and returns #1 after the edge on which it transferred
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic gap(input int k);
        bus.in_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [15:0] a, input logic [15:0] n);
        send(8'hA5);
        send(a[15:8]);
        send(a[7:0]);
        send(n[15:8]);
        send(n[7:0]);
    endtask

    task automatic send_csum(input logic [7:0] c);
        if (CSUM_ON) send(c);
    endtask

    initial begin
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_clken", 32'(bus.sram_clken), 32'd0);
        chk("rst_busy_write_done", {29'd0, bus.busy, bus.sram_write, bus.done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_clken", 32'(bus.sram_clken), 32'd1);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;

        // good frame, sum of 12 34 00 03 11 22 33 is AF, so 51 closes it
        clr();
        send(8'hA5);
        chk("A_busy", 32'(bus.busy), 32'd1);
        send(8'h12); send(8'h34); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        send_csum(8'h51);
        gap(6);
        chk("A_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("A_w0", {wa[0], 8'd0, wd[0]}, {16'h1234, 8'd0, 8'h11});
            chk("A_w1", {wa[1], 8'd0, wd[1]}, {16'h1235, 8'd0, 8'h22});
            chk("A_w2", {wa[2], 8'd0, wd[2]}, {16'h1236, 8'd0, 8'h33});
            chk("A_contig", 32'((wc[1] - wc[0]) * 16 + (wc[2] - wc[1])), 32'h11);
        end
        chk("A_done", done_cnt, 1);
        chk("A_err", 32'(last_err), 32'd0);
        chk("A_ovl_cs", ovl + cs_bad + stray_err, 0);

        // same frame, checksum off by one
        clr();
        send_hdr(16'h1234, 16'd3);
        send(8'h11); send(8'h22); send(8'h33);
        send_csum(8'h52);
        gap(6);
        chk("B_nwr", wa.size(), 3);
        if (wa.size() == 3)
            chk("B_w2", {wa[2], 8'd0, wd[2]}, {16'h1236, 8'd0, 8'h33});
        chk("B_done", done_cnt, 1);
        chk("B_err", 32'(last_err), 32'(CSUM_ON));
        chk("B_ovl", ovl + stray_err, 0);

        // address wrap, FF+FF+00+02+AA+BB = 65 so 9B closes it
        clr();
        send_hdr(16'hFFFF, 16'd2);
        send(8'hAA); send(8'hBB);
        send_csum(8'h9B);
        gap(6);
        chk("W_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("W_w0", {wa[0], 8'd0, wd[0]}, {16'hFFFF, 8'd0, 8'hAA});
            chk("W_w1", {wa[1], 8'd0, wd[1]}, {16'h0000, 8'd0, 8'hBB});
        end
        chk("W_done_err", {done_cnt[15:0], 15'd0, last_err}, {16'd1, 16'd0});

        // leading garbage then an empty frame
        clr();
        send(8'h00); send(8'hFF);
        chk("Z_idle_busy", 32'(bus.busy), 32'd0);
        send_hdr(16'h0010, 16'd0);
        send_csum(8'hF0);
        gap(6);
        chk("Z_nwr", wa.size(), 0);
        chk("Z_done", done_cnt, 1);
        chk("Z_err", 32'(last_err), 32'd0);

        // idle gaps in the payload, 20+04+01+02+03+04 = 2E so D2 closes it
        clr();
        send_hdr(16'h2000, 16'd4);
        send(8'h01); gap(2);
        send(8'h02); gap(1);
        send(8'h03); gap(3);
        send(8'h04);
        send_csum(8'hD2);
        gap(6);
        chk("G_nwr", wa.size(), 4);
        if (wa.size() == 4)
            for (int i = 0; i < 4; i++)
                chk($sformatf("G_w%0d", i), {wa[i], 8'd0, wd[i]},
                    {16'h2000 + 16'(i), 8'd0, 8'(i + 1)});
        chk("G_done_err", {done_cnt[15:0], 15'd0, last_err}, {16'd1, 16'd0});

        // reset pulse after two of four payload bytes
        clr();
        send_hdr(16'h3000, 16'd4);
        send(8'h55); send(8'h66);
        gap(1);
        reset_n = 1'b0;
        #1;
        chk("R_outs", {26'd0, bus.in_ready, bus.sram_clken, bus.sram_write, bus.busy, bus.done, bus.error}, 32'd0);
        chk("R_addr", 32'(bus.sram_address), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        gap(4);
        chk("R_nwr", wa.size(), 2);
        chk("R_done", done_cnt, 0);

        // next complete frame loads, 40+01+77 = B8 so 48 closes it
        clr();
        send_hdr(16'h4000, 16'd1);
        send(8'h77);
        send_csum(8'h48);
        gap(6);
        chk("N_nwr", wa.size(), 1);
        if (wa.size() == 1)
            chk("N_w0", {wa[0], 8'd0, wd[0]}, {16'h4000, 8'd0, 8'h77});
        chk("N_done_err", {done_cnt[15:0], 15'd0, last_err}, {16'd1, 16'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
